// File: rtl/pwq_pkg.sv
// Shared encodings, pipeline depth and the clamp helper used by the
// piecewise-quadratic activation unit.
package pwq_pkg;

   typedef enum logic [1:0] {
      SEL_K0   = 2'd0,
      SEL_K1   = 2'd1,
      SEL_B    = 2'd2,
      SEL_NONE = 2'd3
   } sel_e;

   typedef enum logic {
      MODE_TANH = 1'b0,
      MODE_SIGM = 1'b1
   } mode_e;

   localparam int PIPE_DEPTH = 5;
   localparam int SAT_W      = 64;

   typedef logic signed [SAT_W-1:0] wide_t;

   // Symmetric clamp to +/-(2^(dw-1)-1): the most negative code is never
   // produced, so negating a clamped value can never overflow.
   function automatic wide_t saturate(input wide_t v, input int dw);
      wide_t lim;
      lim = (wide_t'(1) <<< (dw - 1)) - wide_t'(1);
      if (v > lim) return lim;
      if (v < -lim) return -lim;
      return v;
   endfunction

endpackage

// File: rtl/pwq_coef_tbl.sv
// Coefficient register file: 2*NSEG entries of {k0, k1, b}, one write
// port and one combinational read of all three coefficients.
module pwq_coef_tbl
   import pwq_pkg::*;
#(
   parameter int DW       = 16,
   parameter int SEG_BITS = 3
) (
   input  logic                clk,
   input  logic                we,
   input  logic [SEG_BITS+2:0] waddr,
   input  logic [DW-1:0]       wdata,
   input  logic [SEG_BITS:0]   raddr,
   output logic [DW-1:0]       k0,
   output logic [DW-1:0]       k1,
   output logic [DW-1:0]       b
);

   localparam int NENT = 2 ** (SEG_BITS + 1);

   logic [DW-1:0]     k0_mem [NENT];
   logic [DW-1:0]     k1_mem [NENT];
   logic [DW-1:0]     b_mem  [NENT];
   logic [SEG_BITS:0] widx;
   sel_e              wsel;

   assign widx = waddr[SEG_BITS+2:2];
   assign wsel = sel_e'(waddr[1:0]);

   // No reset: contents survive rst and are programmed by software.
   always_ff @(posedge clk) begin
      if (we) begin
         case (wsel)
            SEL_K0:  k0_mem[widx] <= wdata;
            SEL_K1:  k1_mem[widx] <= wdata;
            SEL_B:   b_mem[widx]  <= wdata;
            default: ;
         endcase
      end
   end

   assign k0 = k0_mem[raddr];
   assign k1 = k1_mem[raddr];
   assign b  = b_mem[raddr];

endmodule

// File: rtl/pwq_act.sv
// Piecewise-quadratic activation (tanh / sigmoid symmetry), 5-stage
// pipeline with a single global stall driven by the output handshake.
module pwq_act
   import pwq_pkg::*;
#(
   parameter int DW        = 16,
   parameter int FRAC      = 12,
   parameter int SEG_BITS  = 3,
   parameter int SEG_SHIFT = 12
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                in_valid,
   output logic                in_ready,
   input  logic [DW-1:0]       din,
   input  logic                mode,
   output logic                out_valid,
   input  logic                out_ready,
   output logic [DW-1:0]       dout,
   input  logic                cfg_we,
   input  logic [SEG_BITS+2:0] cfg_addr,
   input  logic [DW-1:0]       cfg_wdata
);

   localparam int NSEG = 2 ** SEG_BITS;
   localparam logic signed [DW-1:0] MAXV = {1'b0, {(DW-1){1'b1}}};
   localparam logic signed [DW-1:0] MINV = {1'b1, {(DW-1){1'b0}}};
   localparam logic signed [DW+1:0] ONE  = (DW+2)'(1) << FRAC;

   logic                  adv;
   logic [PIPE_DEPTH:0]   vld_pipe;

   assign adv         = !out_valid || out_ready;
   assign in_ready    = adv;
   assign vld_pipe[0] = in_valid;
   assign out_valid   = vld_pipe[PIPE_DEPTH];

   always_ff @(posedge clk) begin
      if (rst)      vld_pipe[PIPE_DEPTH:1] <= '0;
      else if (adv) vld_pipe[PIPE_DEPTH:1] <= vld_pipe[PIPE_DEPTH-1:0];
   end

   // Stage 0: magnitude, segment select and coefficient read.
   logic signed [DW-1:0]  x, a0;
   logic [DW-1:0]         seg_raw;
   logic [SEG_BITS-1:0]   seg0;
   logic [DW-1:0]         c_k0, c_k1, c_b;

   assign x = din;

   always_comb begin
      if (!x[DW-1])     a0 = x;
      else if (x == MINV) a0 = MAXV;
      else              a0 = -x;
   end

   assign seg_raw = $unsigned(a0) >> SEG_SHIFT;
   assign seg0    = (seg_raw > DW'(NSEG - 1)) ? SEG_BITS'(NSEG - 1) : seg_raw[SEG_BITS-1:0];

   pwq_coef_tbl #(.DW(DW), .SEG_BITS(SEG_BITS)) u_tbl (
      .clk   (clk),
      .we    (cfg_we),
      .waddr (cfg_addr),
      .wdata (cfg_wdata),
      .raddr ({mode, seg0}),
      .k0    (c_k0),
      .k1    (c_k1),
      .b     (c_b)
   );

   // Stage 1: registered operands.
   logic                 s1_neg;
   mode_e                s1_mode;
   logic signed [DW-1:0] s1_a, s1_k0, s1_k1, s1_b;

   always_ff @(posedge clk) begin
      if (adv && vld_pipe[0]) begin
         s1_neg  <= x[DW-1];
         s1_mode <= mode_e'(mode);
         s1_a    <= a0;
         s1_k0   <= c_k0;
         s1_k1   <= c_k1;
         s1_b    <= c_b;
      end
   end

   // Stage 2: a^2 and k1*a.
   logic signed [2*DW-1:0] p_aa, p_k1;
   logic                   s2_neg;
   mode_e                  s2_mode;
   logic signed [DW-1:0]   s2_a2, s2_t1, s2_k0, s2_b;

   assign p_aa = (2*DW)'(s1_a) * (2*DW)'(s1_a);
   assign p_k1 = (2*DW)'(s1_k1) * (2*DW)'(s1_a);

   always_ff @(posedge clk) begin
      if (adv && vld_pipe[1]) begin
         s2_a2   <= DW'(saturate(SAT_W'(p_aa >>> FRAC), DW));
         s2_t1   <= DW'(saturate(SAT_W'(p_k1 >>> FRAC), DW));
         s2_k0   <= s1_k0;
         s2_b    <= s1_b;
         s2_neg  <= s1_neg;
         s2_mode <= s1_mode;
      end
   end

   // Stage 3: k0*a^2.
   logic signed [2*DW-1:0] p_k0;
   logic                   s3_neg;
   mode_e                  s3_mode;
   logic signed [DW-1:0]   s3_t0, s3_t1, s3_b;

   assign p_k0 = (2*DW)'(s2_k0) * (2*DW)'(s2_a2);

   always_ff @(posedge clk) begin
      if (adv && vld_pipe[2]) begin
         s3_t0   <= DW'(saturate(SAT_W'(p_k0 >>> FRAC), DW));
         s3_t1   <= s2_t1;
         s3_b    <= s2_b;
         s3_neg  <= s2_neg;
         s3_mode <= s2_mode;
      end
   end

   // Stage 4: three-term sum with two guard bits.
   logic                 s4_neg;
   mode_e                s4_mode;
   logic signed [DW+1:0] s4_sum, corr;

   always_ff @(posedge clk) begin
      if (adv && vld_pipe[3]) begin
         s4_sum  <= (DW+2)'(s3_t0) + (DW+2)'(s3_t1) + (DW+2)'(s3_b);
         s4_neg  <= s3_neg;
         s4_mode <= s3_mode;
      end
   end

   // Stage 5: symmetry correction for negative inputs, final clamp.
   always_comb begin
      corr = s4_sum;
      if (s4_neg) corr = (s4_mode == MODE_TANH) ? -s4_sum : ONE - s4_sum;
   end

   always_ff @(posedge clk) begin
      if (rst)                     dout <= '0;
      else if (adv && vld_pipe[4]) dout <= DW'(saturate(SAT_W'(corr), DW));
   end

endmodule

// File: doc/pwq_act.md
PWQ_ACT -- requirements
Module: pwq_act

Interface
REQ-001 SHALL have parameter DW, default 16: signed data width, two's complement.
REQ-002 SHALL have parameter FRAC, default 12: fractional bits of din, dout and coefficients.
REQ-003 SHALL have parameter SEG_BITS, default 3: log2 of the segment count per mode (NSEG = 2^SEG_BITS).
REQ-004 SHALL have parameter SEG_SHIFT, default 12: segment index = |x| >> SEG_SHIFT, saturated to NSEG-1.
REQ-005 SHALL have port clk, input, 1: the single clock, rising edge.
REQ-006 SHALL have port rst, input, 1: reset, synchronous and active-high.
REQ-007 SHALL have port in_valid, input, 1: din/mode qualifier.
REQ-008 SHALL have port in_ready, output, 1: input accepted when in_valid && in_ready.
REQ-009 SHALL have port din, input, DW: operand x.
REQ-010 SHALL have port mode, input, 1: 0 = odd symmetry (tanh), 1 = sigmoid symmetry; carried per sample.
REQ-011 SHALL have port out_valid, output, 1: dout qualifier.
REQ-012 SHALL have port out_ready, input, 1: downstream accept.
REQ-013 SHALL have port dout, output, DW: f(x).
REQ-014 SHALL have port cfg_we, input, 1: coefficient table write strobe.
REQ-015 SHALL have port cfg_addr, input, SEG_BITS+3: {mode, seg, sel[1:0]}, where sel 0 = k0, 1 = k1, 2 = b, 3 = ignored.
REQ-016 SHALL have port cfg_wdata, input, DW: coefficient value in signed Q(DW-FRAC).FRAC.

Function
REQ-017 SHALL compute, with a = |x| and s = seg(a): y = k0[m][s]*a*a + k1[m][s]*a + b[m][s].
REQ-018 SHALL output y when x>=0; when x<0, SHALL output -y for mode 0 and (1.0 - y) for mode 1.
REQ-019 SHALL compute |x| of the most negative din as 2^(DW-1)-1.
REQ-020 SHALL form each product at full 2*DW width, arithmetic-shift it right by FRAC, and saturate it to DW signed.
REQ-021 SHALL compute the three-term sum in DW+2 bits, apply the sign/mode correction, then saturate to DW signed.
REQ-022 SHALL have fixed latency 5 cycles from acceptance to out_valid when never stalled, with one sample accepted per cycle throughput.
REQ-023 SHALL use a global stall: the pipeline advances iff !out_valid || out_ready; in_ready equals that advance term.
REQ-024 SHALL hold dout and out_valid stable while out_valid && !out_ready, with no sample lost, duplicated or reordered.
REQ-025 SHALL let bubbles (in_valid=0) propagate as invalid stages that do not produce out_valid.
REQ-026 SHALL read the coefficients for a sample into the pipeline in the acceptance cycle; a cfg write in the same cycle is not visible to that sample and is visible to the next accepted sample.
REQ-027 SHALL accept cfg_we regardless of the stall state; sel=3 writes have no effect.

Reset
REQ-028 SHALL, under rst, clear all stage valids, out_valid=0 and dout=0; in_ready reads 1 in the first cycle after reset.
REQ-029 SHALL discard in-flight samples on reset mid-stream, producing no out_valid afterwards for them.
REQ-030 SHALL leave coefficient table contents unaffected by rst (undefined at power-up; software programs it before use).

Structure
REQ-031 SHALL place the sel encodings, mode encodings, pipeline depth constant (5) and the saturate function in shared package pwq_pkg.
REQ-032 SHALL instantiate one sub-module pwq_coef_tbl: a 2*NSEG x 3 register file with one write port and one combinational read port of three coefficients.

Verification
REQ-033 Mode 0, seg0: k0=0, k1=0x1000, b=0; din 0x0800 -> dout 0x0800 5 cycles later; din 0xF800 -> 0xF800.
REQ-034 Mode 1, seg0: k0=0, k1=0, b=0x0C00; din 0x0400 -> 0x0C00; din 0xFC00 -> 0x0400.
REQ-035 Mode 0, last seg: k1=0x7FFF, b=0x7FFF; din 0x7FFF -> 0x7FFF; din 0x8000 -> 0x8001 (saturation, with |min| handled per REQ-019).
REQ-036 Back-to-back stream of 8 samples with out_ready low for cycles 3-12 -> all 8 outputs in order, dout stable while stalled, in_ready low whenever out_valid && !out_ready.
REQ-037 Assert rst for 1 cycle with 3 samples in flight -> out_valid=0 and dout=0 next cycle, no stale outputs afterwards; table contents retained.
REQ-038 cfg write to seg0 b in the same cycle as a seg0 sample is accepted -> that sample uses the old b and the next sample uses the new b.
